// File: rtl/step2_writeback_if.sv
// Handshake and write-bus bundle for the dot-product writeback stage.
// The master side drives set data and SRAM acceptance; the slave side is the stage itself.
interface step2_writeback_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SET_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [SET_W-1:0]  num_sets;
  logic [15:0]       z0;
  logic [15:0]       z1;
  logic [15:0]       z2;
  logic [15:0]       z3;
  logic              z_valid;
  logic              z_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, num_sets, z0, z1, z2, z3, z_valid, wr_ready,
    input  z_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, base_addr, num_sets, z0, z1, z2, z3, z_valid, wr_ready,
    output z_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/step2_writeback.sv
// Writeback stage: captures four-lane result sets, optionally clamps negatives, buffers two
// sets and streams them word by word into the output SRAM at consecutive addresses.
module step2_writeback #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned SET_W  = 8,
  parameter int unsigned RELU   = 1
) (
  input logic             clock,
  input logic             reset_b,
  step2_writeback_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [SET_W-1:0]       target_q, target_d;
  logic [SET_W-1:0]       accepted_q, accepted_d;
  logic [SET_W-1:0]       written_q, written_d;
  logic [1:0]             count_q, count_d;
  logic                   head_q, head_d;
  logic [1:0]             word_q, word_d;
  logic [1:0][3:0][15:0]  buf_q, buf_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [3:0][15:0]       lanes_in;
  logic                   wr_en;
  logic                   push;
  logic                   pop;
  logic                   word_done;
  logic                   tail;

  always_comb begin
    lanes_in = {bus.z3, bus.z2, bus.z1, bus.z0};
    if (RELU != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_in[i][15]) lanes_in[i] = '0;
      end
    end
  end

  // Acceptance looks only at registered state so a same-cycle pop never opens the input.
  assign bus.z_ready = (state_q == StRun) && (count_q < 2'd2) && (accepted_q < target_q);
  assign wr_en       = (count_q != 2'd0);
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = wr_en ? buf_q[head_q][word_q] : '0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  assign push      = bus.z_valid && bus.z_ready;
  assign word_done = wr_en && bus.wr_ready;
  assign pop       = word_done && (word_q == 2'd3);
  assign tail      = head_q ^ count_q[0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    target_d   = target_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    head_d     = head_q;
    word_d     = word_q;
    buf_d      = buf_q;

    if (push) begin
      buf_d[tail] = lanes_in;
      accepted_d  = accepted_q + SET_W'(1);
    end
    if (word_done) begin
      addr_d = addr_q + ADDR_W'(1);
      word_d = word_q + 2'd1;
    end
    if (pop) begin
      head_d    = ~head_q;
      written_d = written_q + SET_W'(1);
    end
    count_d = count_q + 2'(push) - 2'(pop);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d     = bus.base_addr;
          target_d   = bus.num_sets;
          accepted_d = '0;
          written_d  = '0;
          state_d    = (bus.num_sets == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (accepted_d == target_q) state_d = StDrain;
      end
      StDrain: begin
        if (written_d == target_q) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StFin);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      target_q   <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      count_q    <= '0;
      head_q     <= 1'b0;
      word_q     <= '0;
      buf_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      count_q    <= count_d;
      head_q     <= head_d;
      word_q     <= word_d;
      buf_q      <= buf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_step2_writeback.sv
// Bench for step2_writeback: a ReLU and a pass-through instance share directed stimulus and are
// checked every cycle against a word-queue model, plus literal expectations per scenario.
module tb_step2_writeback;
  localparam int unsigned AW = 10;
  localparam int unsigned SW = 8;

  logic          clock = 1'b0;
  logic          reset_b = 1'b0;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [SW-1:0] num_sets;
  logic [15:0]   z0, z1, z2, z3;
  logic          z_valid;
  logic          wr_ready;

  always #5 clock = ~clock;

  step2_writeback_if #(.ADDR_W(AW), .SET_W(SW)) bus1 ();
  step2_writeback_if #(.ADDR_W(AW), .SET_W(SW)) bus0 ();

  assign bus1.start = start;     assign bus0.start = start;
  assign bus1.base_addr = base_addr; assign bus0.base_addr = base_addr;
  assign bus1.num_sets = num_sets;   assign bus0.num_sets = num_sets;
  assign bus1.z0 = z0; assign bus1.z1 = z1; assign bus1.z2 = z2; assign bus1.z3 = z3;
  assign bus0.z0 = z0; assign bus0.z1 = z1; assign bus0.z2 = z2; assign bus0.z3 = z3;
  assign bus1.z_valid = z_valid;   assign bus0.z_valid = z_valid;
  assign bus1.wr_ready = wr_ready; assign bus0.wr_ready = wr_ready;

  step2_writeback #(.ADDR_W(AW), .SET_W(SW), .RELU(1)) u_relu (
    .clock  (clock),
    .reset_b(reset_b),
    .bus    (bus1)
  );

  step2_writeback #(.ADDR_W(AW), .SET_W(SW), .RELU(0)) u_pass (
    .clock  (clock),
    .reset_b(reset_b),
    .bus    (bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
    return v[15] ? 16'h0000 : v;
  endfunction

  // Model: every accepted set becomes four pending (addr, raw data) words.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } word_t;

  word_t         m_q[$];
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_target = 0;
  int            m_accepted = 0;
  int            m_written = 0;
  logic [AW-1:0] m_addr = '0;

  word_t         log1[$];
  logic [15:0]   log0[$];

  always @(negedge clock) begin : cmp
    logic        zr_exp;
    logic        done_next;
    int          pend_sets;
    logic [15:0] lz [4];
    word_t       w;
    if (!reset_b) begin
      m_q.delete();
      m_busy = 1'b0; m_done = 1'b0;
      m_target = 0; m_accepted = 0; m_written = 0;
      chk("rst_z_ready", {31'b0, bus1.z_ready}, 0);
      chk("rst_wr_en", {31'b0, bus1.wr_en}, 0);
      chk("rst_busy", {31'b0, bus1.busy}, 0);
      chk("rst_done", {31'b0, bus1.done}, 0);
      chk("rst_wr_addr", {22'b0, bus1.wr_addr}, 0);
      chk("rst_wr_data", {16'b0, bus1.wr_data}, 0);
      chk("rst_wr_en_pass", {31'b0, bus0.wr_en}, 0);
      chk("rst_wr_data_pass", {16'b0, bus0.wr_data}, 0);
    end else begin
      pend_sets = (m_q.size() + 3) / 4;
      zr_exp = m_busy && (m_accepted < m_target) && (pend_sets < 2);
      chk("z_ready", {31'b0, bus1.z_ready}, {31'b0, zr_exp});
      chk("z_ready_pass", {31'b0, bus0.z_ready}, {31'b0, zr_exp});
      chk("wr_en", {31'b0, bus1.wr_en}, {31'b0, m_q.size() != 0});
      chk("wr_en_pass", {31'b0, bus0.wr_en}, {31'b0, m_q.size() != 0});
      chk("busy", {31'b0, bus1.busy}, {31'b0, m_busy});
      chk("done", {31'b0, bus1.done}, {31'b0, m_done});
      chk("done_pass", {31'b0, bus0.done}, {31'b0, m_done});
      if (m_q.size() != 0) begin
        chk("wr_addr", {22'b0, bus1.wr_addr}, {22'b0, m_q[0].addr});
        chk("wr_addr_pass", {22'b0, bus0.wr_addr}, {22'b0, m_q[0].addr});
        chk("wr_data_relu", {16'b0, bus1.wr_data}, {16'b0, relu(m_q[0].data)});
        chk("wr_data_pass", {16'b0, bus0.wr_data}, {16'b0, m_q[0].data});
      end
      if (bus1.wr_en && wr_ready) begin
        w.addr = bus1.wr_addr;
        w.data = bus1.wr_data;
        log1.push_back(w);
        log0.push_back(bus0.wr_data);
      end
      // Advance the model to the state after the coming rising edge.
      done_next = 1'b0;
      if (m_q.size() != 0 && wr_ready) begin
        void'(m_q.pop_front());
        m_written++;
        if (m_busy && m_written == 4 * m_target) begin
          m_busy = 1'b0;
          done_next = 1'b1;
        end
      end
      if (zr_exp && z_valid) begin
        lz[0] = z0; lz[1] = z1; lz[2] = z2; lz[3] = z3;
        for (int i = 0; i < 4; i++) begin
          w.addr = m_addr;
          w.data = lz[i];
          m_q.push_back(w);
          m_addr = m_addr + 1'b1;
        end
        m_accepted++;
      end
      if (start && !m_busy && !m_done) begin
        m_target = int'(num_sets);
        m_addr = base_addr;
        m_accepted = 0;
        m_written = 0;
        if (num_sets == '0) done_next = 1'b1;
        else m_busy = 1'b1;
      end
      m_done = done_next;
    end
  end

  logic [15:0] sets [10][4];

  task automatic load(input int s);
    z0 = sets[s][0]; z1 = sets[s][1]; z2 = sets[s][2]; z3 = sets[s][3];
  endtask

  // Runs one job, holding z_valid high throughout; wr_ready is low for the first `stall` cycles.
  task automatic run_job(input logic [AW-1:0] base, input int n, input int first_set,
                         input int stall, output int done_cyc, output int stall_acc);
    int   idx;
    logic xfer;
    logic d;
    log1.delete();
    log0.delete();
    done_cyc  = -1;
    stall_acc = 0;
    d         = 1'b0;
    start     = 1'b1;
    base_addr = base;
    num_sets  = n[SW-1:0];
    wr_ready  = (stall == 0);
    @(posedge clock); #1;
    start   = 1'b0;
    idx     = 0;
    load(first_set);
    z_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      xfer = z_valid && bus1.z_ready;
      d    = bus1.done;
      if (d) begin
        done_cyc = c;
        break;
      end
      @(posedge clock); #1;
      if (xfer) begin
        if (c < stall) stall_acc++;
        idx++;
        load(first_set + idx);
      end
      wr_ready = (c + 1 >= stall);
    end
    chk("job_done_seen", {31'b0, d}, 1);
    z_valid  = 1'b0;
    wr_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  int          dc, sa;
  logic [15:0] exp_relu [4];
  logic [15:0] exp_pass [4];
  logic [AW-1:0] exp_addr [4];

  initial begin
    sets[0] = '{16'h0005, 16'hFFFE, 16'h7FFF, 16'h8000};
    sets[1] = '{16'h1234, 16'h8001, 16'h0001, 16'hFFFF};
    sets[2] = '{16'h7000, 16'h0A0A, 16'hC000, 16'h0002};
    sets[3] = '{16'h0003, 16'h0004, 16'h9999, 16'h0100};
    sets[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    sets[5] = '{16'h00AA, 16'h80AA, 16'h7FFE, 16'h0001};
    sets[6] = '{16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567};
    sets[7] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    sets[8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    sets[9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    start = 1'b0; base_addr = '0; num_sets = '0;
    z0 = '0; z1 = '0; z2 = '0; z3 = '0;
    z_valid = 1'b0; wr_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_b = 1'b1;
    @(posedge clock); #1;

    // Single set with negative lanes.
    run_job(10'h010, 1, 0, 0, dc, sa);
    exp_relu = '{16'h0005, 16'h0000, 16'h7FFF, 16'h0000};
    exp_pass = '{16'h0005, 16'hFFFE, 16'h7FFF, 16'h8000};
    exp_addr = '{10'h010, 10'h011, 10'h012, 10'h013};
    chk("single_done_cycle", dc, 5);
    chk("single_words", log1.size(), 4);
    for (int i = 0; i < 4 && i < log1.size(); i++) begin
      chk("single_addr", {22'b0, log1[i].addr}, {22'b0, exp_addr[i]});
      chk("single_data_relu", {16'b0, log1[i].data}, {16'b0, exp_relu[i]});
      chk("single_data_pass", {16'b0, log0[i]}, {16'b0, exp_pass[i]});
    end

    // Backpressure: three sets, SRAM stalled for ten cycles.
    run_job(10'h040, 3, 1, 10, dc, sa);
    chk("bp_accepts_in_stall", sa, 2);
    chk("bp_words", log1.size(), 12);
    for (int i = 0; i < log1.size(); i++) begin
      chk("bp_addr", {22'b0, log1[i].addr}, 32'h40 + i);
    end
    if (log1.size() >= 5) chk("bp_word4_relu", {16'b0, log1[4].data}, 32'h7000);
    if (log1.size() >= 7) chk("bp_word6_relu", {16'b0, log1[6].data}, 32'h0000);

    // Zero count.
    run_job(10'h123, 0, 4, 0, dc, sa);
    chk("zero_done_cycle", dc, 0);
    chk("zero_words", log1.size(), 0);

    // Address wrap.
    run_job(10'h3FE, 1, 5, 0, dc, sa);
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    exp_relu = '{16'h00AA, 16'h0000, 16'h7FFE, 16'h0001};
    chk("wrap_words", log1.size(), 4);
    for (int i = 0; i < 4 && i < log1.size(); i++) begin
      chk("wrap_addr", {22'b0, log1[i].addr}, {22'b0, exp_addr[i]});
      chk("wrap_data", {16'b0, log1[i].data}, {16'b0, exp_relu[i]});
    end

    // Reset after two of four words.
    start = 1'b1; base_addr = 10'h200; num_sets = 8'd1; wr_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; load(6); z_valid = 1'b1;
    @(posedge clock); #1;
    z_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset_b = 1'b0;
    #1;
    chk("midrst_wr_en", {31'b0, bus1.wr_en}, 0);
    chk("midrst_wr_addr", {22'b0, bus1.wr_addr}, 0);
    chk("midrst_wr_data", {16'b0, bus1.wr_data}, 0);
    chk("midrst_busy", {31'b0, bus1.busy}, 0);
    chk("midrst_z_ready", {31'b0, bus1.z_ready}, 0);
    chk("midrst_done", {31'b0, bus1.done}, 0);
    @(posedge clock); #1;
    reset_b = 1'b1;
    @(posedge clock); #1;
    run_job(10'h100, 1, 7, 0, dc, sa);
    chk("postrst_words", log1.size(), 4);
    for (int i = 0; i < 4 && i < log1.size(); i++) begin
      chk("postrst_addr", {22'b0, log1[i].addr}, 32'h100 + i);
      chk("postrst_data", {16'b0, log1[i].data}, 32'h1111 * (i + 1));
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
